// File: rtl/mole_game_engine_if.sv
// Game I/O bundle: debounced start and switches in, mole LEDs and binary counts out.
interface mole_game_engine_if #(
    parameter int unsigned N_HOLES    = 16,
    parameter int unsigned SCORE_BITS = 8
);
    logic                  start;
    logic [N_HOLES-1:0]    sw;
    logic [N_HOLES-1:0]    led;
    logic [SCORE_BITS-1:0] score;
    logic [SCORE_BITS-1:0] misses;
    logic [7:0]            time_left;
    logic                  playing;
    logic                  game_over;

    modport master (
        output start, sw,
        input  led, score, misses, time_left, playing, game_over
    );

    modport slave (
        input  start, sw,
        output led, score, misses, time_left, playing, game_over
    );
endinterface

// File: rtl/mole_game_engine.sv
// Whack-a-mole core: LFSR mole placement, ms/second timebase, hit/miss scoring
// and a mole window that shrinks as the score rises.
module mole_game_engine #(
    parameter int unsigned N_HOLES         = 16,
    parameter int unsigned CLK_IN_FREQ_HZ  = 100_000_000,
    parameter int unsigned GAME_SECONDS    = 30,
    parameter int unsigned MOLE_UP_MS_INIT = 1000,
    parameter int unsigned MOLE_UP_MS_MIN  = 300,
    parameter int unsigned SPEEDUP_MS      = 50,
    parameter int unsigned GAP_MS          = 100,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned SCORE_BITS      = 8
) (
    input  logic clk,
    input  logic reset,
    mole_game_engine_if.slave bus
);
    localparam int unsigned PRESCALE = CLK_IN_FREQ_HZ / 1000;
    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned MS_W     = 10;
    localparam int unsigned WIN_W    = 16;
    localparam int unsigned HOLE_W   = $clog2(N_HOLES);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

    state_t                state_q, state_n;
    logic [PRE_W-1:0]      presc_q, presc_n;
    logic [MS_W-1:0]       ms_cnt_q, ms_cnt_n;
    logic [WIN_W-1:0]      gap_cnt_q, gap_cnt_n;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_n;
    logic [WIN_W-1:0]      up_ms_q, up_ms_n;
    logic [15:0]           lfsr_q, lfsr_n;
    logic [N_HOLES-1:0]    sw_q;
    logic [HOLE_W-1:0]     hole_q, hole_n;
    logic                  prev_valid_q, prev_valid_n;
    logic [N_HOLES-1:0]    led_q, led_n;
    logic [SCORE_BITS-1:0] score_q, score_n;
    logic [SCORE_BITS-1:0] misses_q, misses_n;
    logic [7:0]            time_left_q, time_left_n;
    logic                  playing_q, game_over_q;

    logic [N_HOLES-1:0]    whack;
    logic                  in_round, ms_tick, sec_tick;
    logic [7:0]            hole_raw;
    logic [HOLE_W-1:0]     hole_pick;

    assign whack    = bus.sw ^ sw_q;
    assign in_round = (state_q == GAP) || (state_q == UP);
    assign ms_tick  = in_round && (presc_q == PRE_W'(PRESCALE - 1));
    assign sec_tick = ms_tick && (ms_cnt_q == MS_W'(999));

    // Next hole never repeats the previous one back-to-back.
    always_comb begin
        hole_raw  = lfsr_q[7:0] % 8'(N_HOLES);
        hole_pick = HOLE_W'(hole_raw);
        if (prev_valid_q && (hole_pick == hole_q)) begin
            hole_pick = (hole_pick == HOLE_W'(N_HOLES - 1)) ? '0 : hole_pick + HOLE_W'(1);
        end
    end

    always_comb begin
        state_n      = state_q;
        lfsr_n       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        presc_n      = presc_q;
        ms_cnt_n     = ms_cnt_q;
        gap_cnt_n    = gap_cnt_q;
        win_cnt_n    = win_cnt_q;
        up_ms_n      = up_ms_q;
        hole_n       = hole_q;
        prev_valid_n = prev_valid_q;
        led_n        = led_q;
        score_n      = score_q;
        misses_n     = misses_q;
        time_left_n  = time_left_q;

        if (in_round) begin
            presc_n = ms_tick ? '0 : presc_q + PRE_W'(1);
            if (ms_tick) begin
                ms_cnt_n = (ms_cnt_q == MS_W'(999)) ? '0 : ms_cnt_q + MS_W'(1);
            end
            if (sec_tick && (time_left_q != 8'd0)) begin
                time_left_n = time_left_q - 8'd1;
            end
        end

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_n      = GAP;
                    presc_n      = '0;
                    ms_cnt_n     = '0;
                    gap_cnt_n    = '0;
                    score_n      = '0;
                    misses_n     = '0;
                    time_left_n  = 8'(GAME_SECONDS);
                    up_ms_n      = WIN_W'(MOLE_UP_MS_INIT);
                    prev_valid_n = 1'b0;
                    led_n        = '0;
                end
            end
            GAP: begin
                if (ms_tick) begin
                    if (gap_cnt_q >= WIN_W'(GAP_MS - 1)) begin
                        state_n      = UP;
                        hole_n       = hole_pick;
                        prev_valid_n = 1'b1;
                        led_n        = N_HOLES'(1) << hole_pick;
                        win_cnt_n    = '0;
                    end else begin
                        gap_cnt_n = gap_cnt_q + WIN_W'(1);
                    end
                end
            end
            UP: begin
                if (ms_tick) begin
                    win_cnt_n = win_cnt_q + WIN_W'(1);
                end
                if (whack[hole_q]) begin
                    state_n   = GAP;
                    gap_cnt_n = '0;
                    led_n     = '0;
                    if (score_q != {SCORE_BITS{1'b1}}) begin
                        score_n = score_q + SCORE_BITS'(1);
                    end
                    up_ms_n = (up_ms_q >= WIN_W'(MOLE_UP_MS_MIN + SPEEDUP_MS))
                              ? up_ms_q - WIN_W'(SPEEDUP_MS) : WIN_W'(MOLE_UP_MS_MIN);
                end else if (|whack) begin
                    if (misses_q != {SCORE_BITS{1'b1}}) begin
                        misses_n = misses_q + SCORE_BITS'(1);
                    end
                end else if (ms_tick && (win_cnt_q >= up_ms_q - WIN_W'(1))) begin
                    state_n   = GAP;
                    gap_cnt_n = '0;
                    led_n     = '0;
                    if (misses_q != {SCORE_BITS{1'b1}}) begin
                        misses_n = misses_q + SCORE_BITS'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Round end overrides the game state; a same-cycle hit above still scores.
        if (in_round && (time_left_q == 8'd0)) begin
            state_n = OVER;
            led_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        sw_q <= bus.sw;
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            presc_q      <= '0;
            ms_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            win_cnt_q    <= '0;
            up_ms_q      <= WIN_W'(MOLE_UP_MS_INIT);
            hole_q       <= '0;
            prev_valid_q <= 1'b0;
            led_q        <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            time_left_q  <= 8'(GAME_SECONDS);
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            lfsr_q       <= lfsr_n;
            presc_q      <= presc_n;
            ms_cnt_q     <= ms_cnt_n;
            gap_cnt_q    <= gap_cnt_n;
            win_cnt_q    <= win_cnt_n;
            up_ms_q      <= up_ms_n;
            hole_q       <= hole_n;
            prev_valid_q <= prev_valid_n;
            led_q        <= led_n;
            score_q      <= score_n;
            misses_q     <= misses_n;
            time_left_q  <= time_left_n;
            playing_q    <= (state_n == GAP) || (state_n == UP);
            game_over_q  <= (state_n == OVER);
        end
    end

    assign bus.led       = led_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.time_left = time_left_q;
    assign bus.playing   = playing_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_mole_game_engine.sv
// Scoreboarded directed test of mole_game_engine at 10 kHz (10 clocks per ms).
module tb_mole_game_engine;
    localparam int unsigned N     = 16;
    localparam int unsigned SB    = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam logic [3:0] S_LED = 4'd0, S_SCORE = 4'd1, S_MISSES = 4'd2,
                           S_TIME = 4'd3, S_PLAY = 4'd4, S_OVER = 4'd5;

    typedef struct packed {
        logic [31:0] due;
        logic [3:0]  sel;
        logic [31:0] exp;
        logic [15:0] tag;
    } exp_t;

    logic clk;
    logic reset;
    mole_game_engine_if #(.N_HOLES(N), .SCORE_BITS(SB)) bus ();

    mole_game_engine #(
        .N_HOLES(N), .CLK_IN_FREQ_HZ(10_000), .GAME_SECONDS(3),
        .MOLE_UP_MS_INIT(1000), .MOLE_UP_MS_MIN(300), .SPEEDUP_MS(50),
        .GAP_MS(2), .LFSR_SEED(SEED), .SCORE_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    logic [15:0] tag_c = 16'd0;
    logic [15:0] m_lfsr;

    int t, es, em, h, prev_h, te, tu;
    bit prev_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference 16-bit Galois LFSR, taps 16,14,13,11.
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic string sname(input logic [3:0] s);
        case (s)
            S_LED:    return "led";
            S_SCORE:  return "score";
            S_MISSES: return "misses";
            S_TIME:   return "time_left";
            S_PLAY:   return "playing";
            default:  return "game_over";
        endcase
    endfunction

    function automatic logic [31:0] actual(input logic [3:0] s);
        case (s)
            S_LED:    return 32'(bus.led);
            S_SCORE:  return 32'(bus.score);
            S_MISSES: return 32'(bus.misses);
            S_TIME:   return 32'(bus.time_left);
            S_PLAY:   return 32'(bus.playing);
            default:  return 32'(bus.game_over);
        endcase
    endfunction

    // Monitor: pops every expectation that has come due and compares it.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e   = sbq.pop_front();
            mon_act = actual(mon_e.sel);
            n_vec++;
            if (mon_act !== mon_e.exp) begin
                n_err++;
                $display("FAIL %s #%0d @t=%0d: got %0d expected %0d",
                         sname(mon_e.sel), mon_e.tag, t, mon_act, mon_e.exp);
            end
        end
    end

    task automatic chk(input logic [3:0] sel, input logic [31:0] v);
        exp_t e;
        e.due = cyc; e.sel = sel; e.exp = v; e.tag = tag_c;
        sbq.push_back(e);
        tag_c++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto_t(input int tt);
        while (t < tt) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    function automatic int calc_hole(input logic [15:0] l);
        int r;
        r = int'(l[7:0]) % N;
        if (prev_v && r == prev_h) r = (r + 1) % N;
        return r;
    endfunction

    // From within GAP, mole rises on the second ms edge after the gap began.
    task automatic wait_mole(output int hole);
        int exp_edge;
        exp_edge = 10 * (t / 10 + 2);
        goto_t(exp_edge - 1);
        hole = calc_hole(m_lfsr);
        chk(S_LED, 32'd0);
        goto_t(exp_edge);
        chk(S_LED, 32'd1 << hole);
        prev_h = hole;
        prev_v = 1'b1;
    endtask

    task automatic hit(input int hole, input logic [15:0] extra);
        bus.sw = bus.sw ^ (16'(1) << hole) ^ extra;
        step();
        es = (es < 255) ? es + 1 : 255;
        chk(S_SCORE, 32'(es));
        chk(S_MISSES, 32'(em));
        chk(S_LED, 32'd0);
    endtask

    task automatic wrong(input int hole, input logic [15:0] mask);
        bus.sw = bus.sw ^ mask;
        step();
        em++;
        chk(S_MISSES, 32'(em));
        chk(S_LED, 32'd1 << hole);
    endtask

    task automatic chk_reset_vals();
        chk(S_LED, 32'd0);     chk(S_SCORE, 32'd0); chk(S_MISSES, 32'd0);
        chk(S_TIME, 32'd3);    chk(S_PLAY, 32'd0);  chk(S_OVER, 32'd0);
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.sw = 16'h0; t = 0;
        es = 0; em = 0; prev_h = 0; prev_v = 1'b0;
        step(); step();
        chk_reset_vals();
        reset = 1'b0;
        step(); step();
        chk(S_PLAY, 32'd0);

        // Round 1
        pulse_start(); t = 0;
        chk(S_PLAY, 32'd1); chk(S_TIME, 32'd3); chk(S_SCORE, 32'd0); chk(S_OVER, 32'd0);
        wait_mole(h);
        wrong(h, 16'(1) << ((h + 1) % N));
        wrong(h, (16'(1) << ((h + 1) % N)) | (16'(1) << ((h + 2) % N)) | (16'(1) << ((h + 3) % N)));
        hit(h, 16'(1) << ((h + 5) % N));
        bus.sw = bus.sw ^ 16'h0F0F;   // whacks during GAP do nothing
        step();
        chk(S_SCORE, 32'(es)); chk(S_MISSES, 32'(em));
        pulse_start();                // start during GAP ignored
        chk(S_PLAY, 32'd1); chk(S_SCORE, 32'(es));
        wait_mole(h);
        goto_t(100);
        pulse_start();                // start during UP ignored
        chk(S_LED, 32'd1 << h); chk(S_SCORE, 32'(es)); chk(S_MISSES, 32'(em));
        // One hit so far: window is 950 ms
        tu = 40;
        goto_t(tu + 9499); chk(S_LED, 32'd1 << h);
        goto_t(tu + 9500); em++; chk(S_LED, 32'd0); chk(S_MISSES, 32'(em));
        wait_mole(h);
        goto_t(9999);  chk(S_TIME, 32'd3);
        goto_t(10000); chk(S_TIME, 32'd2);
        for (int i = 0; i < 13; i++) begin
            hit(h, 16'h0);
            wait_mole(h);
        end
        // Fourteen hits: window at its 300 ms floor
        tu = t;
        goto_t(tu + 2999); chk(S_LED, 32'd1 << h);
        goto_t(tu + 3000); em++; chk(S_LED, 32'd0); chk(S_MISSES, 32'(em));
        wait_mole(h);
        while (es < 255) begin
            hit(h, 16'h0);
            wait_mole(h);
        end
        hit(h, 16'h0);                // saturates at 255
        forever begin
            te = 10 * (t / 10 + 2);
            if (te + 3000 > 30000) break;
            wait_mole(h);
            goto_t(t + 3000);
            em++;
            chk(S_MISSES, 32'(em)); chk(S_LED, 32'd0);
        end
        if (t < 29999) begin
            goto_t(29999); chk(S_TIME, 32'd1); chk(S_OVER, 32'd0);
        end
        goto_t(30000); chk(S_TIME, 32'd0); chk(S_PLAY, 32'd1);
        goto_t(30001);
        chk(S_OVER, 32'd1); chk(S_PLAY, 32'd0); chk(S_LED, 32'd0);
        chk(S_SCORE, 32'd255); chk(S_MISSES, 32'(em));
        n_vec++;
        if (bus.game_over !== 1'b1) begin
            n_err++;
            $display("FAIL direct game_over: got %0d expected 1", bus.game_over);
        end
        n_vec++;
        if (bus.score !== SB'(255)) begin
            n_err++;
            $display("FAIL direct score: got %0d expected 255", bus.score);
        end
        bus.sw = bus.sw ^ 16'hFFFF;   // whacks in OVER frozen out
        step();
        chk(S_SCORE, 32'd255); chk(S_MISSES, 32'(em)); chk(S_LED, 32'd0); chk(S_OVER, 32'd1);
        step();

        // Round 2
        pulse_start(); t = 0; es = 0; em = 0; prev_v = 1'b0;
        chk(S_SCORE, 32'd0); chk(S_MISSES, 32'd0); chk(S_TIME, 32'd3);
        chk(S_PLAY, 32'd1);  chk(S_OVER, 32'd0);
        wait_mole(h);
        goto_t(9999);  chk(S_TIME, 32'd3);
        goto_t(10000); chk(S_TIME, 32'd2);
        goto_t(10019); chk(S_LED, 32'd1 << h);
        goto_t(10020); em++; chk(S_LED, 32'd0); chk(S_MISSES, 32'(em));
        wait_mole(h);
        hit(h, 16'h0);
        wait_mole(h);
        reset = 1'b1;                 // abort mid-UP
        step();
        chk_reset_vals();
        n_vec++;
        if (bus.led !== 16'h0) begin
            n_err++;
            $display("FAIL direct led after reset: got %0h expected 0", bus.led);
        end
        n_vec++;
        if (bus.time_left !== 8'd3) begin
            n_err++;
            $display("FAIL direct time_left after reset: got %0d expected 3", bus.time_left);
        end
        reset = 1'b0;
        step(); step(); step();
        chk(S_PLAY, 32'd0); chk(S_LED, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s #%0d: never checked, expected %0d",
                     sname(mon_e.sel), mon_e.tag, mon_e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: stimulus did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end
endmodule

// File: doc/mole_game_engine.md
Name: mole_game_engine

Overview:
- Parametrised, self-contained whack-a-mole game core. It replaces the fixed-pattern game and free-running timer with a single FSM-controlled engine.
- Features: N holes, LFSR-randomised mole placement, a start/game-over lifecycle, per-round countdown, hit and miss scoring, and a mole-up time that shortens as the score rises.
- Outputs are binary counts only. The existing BCD and 7-segment path downstream consumes score and time_left unchanged.

Parameters:
- N_HOLES, 16, number of holes/switches/LEDs (2..32).
- CLK_IN_FREQ_HZ, 100_000_000, clk frequency. Must be a multiple of 1000.
- GAME_SECONDS, 30, round length in seconds (1..255).
- MOLE_UP_MS_INIT, 1000, initial mole-visible window in ms.
- MOLE_UP_MS_MIN, 300, floor for the mole-visible window.
- SPEEDUP_MS, 50, reduction of the window per hit.
- GAP_MS, 100, blank time between moles.
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Galois LFSR (taps 16,14,13,11).
- SCORE_BITS, 8, width of score and misses.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start pulse, already debounced upstream.
- sw  in  N_HOLES  board switches; any toggle of a bit is a whack on that hole.
- led  out  N_HOLES  one-hot mole indicator; all zero when no mole is up.
- score  out  SCORE_BITS  hits this round, saturating.
- misses  out  SCORE_BITS  wrong-hole whacks plus timeouts, saturating.
- time_left  out  8  seconds remaining.
- playing  out  1  high in GAP or UP.
- game_over  out  1  high in OVER.

Behaviour:
- Reset:
  - state=IDLE; led=0, score=0, misses=0, time_left=GAME_SECONDS, playing=0, game_over=0.
  - lfsr=LFSR_SEED; up_ms=MOLE_UP_MS_INIT; sw_q=sw; internal counters=0.
  - Reset asserted mid-round aborts the round the same edge.
- ms tick:
  - Prescaler counts CLK_IN_FREQ_HZ/1000 clocks and pulses ms_tick for one cycle.
  - The prescaler runs only in GAP/UP and is cleared on entry to GAP from IDLE/OVER.
- Seconds:
  - A ms counter (0..999) emits sec_tick.
  - time_left decrements on sec_tick and holds at 0.
  - The first decrement occurs exactly 1000 ms after start.
- LFSR: advances every clk in all states, so placement depends on when start arrives.
- Whack detect:
  - sw_q <= sw every cycle in every state.
  - whack = sw ^ sw_q, evaluated combinationally.
  - Whacks outside UP are ignored.
- FSM states: IDLE, GAP, UP, OVER.
- IDLE:
  - On start -> GAP. Clear score and misses, time_left=GAME_SECONDS, up_ms=MOLE_UP_MS_INIT.
- GAP:
  - led=0. Counts GAP_MS ms_ticks.
  - At expiry -> UP. hole = lfsr[7:0] mod N_HOLES; if hole equals the previous hole, use hole+1 mod N_HOLES.
  - led becomes one-hot(hole) on the same edge; the window counter is cleared.
- UP, checked in this priority order each cycle:
  1. whack[hole]=1 (hit): score+1 (saturate at all-ones); up_ms = max(up_ms-SPEEDUP_MS, MOLE_UP_MS_MIN); led=0; -> GAP. Other bits toggled in the same cycle are not counted as misses.
  2. Else whack has any other bit set: misses+1 once per cycle regardless of how many bits toggled; stay in UP.
  3. Else window counter reaches up_ms ms_ticks (timeout): misses+1; led=0; -> GAP.
- Round end:
  - When time_left is 0 in GAP/UP -> OVER on the next edge. led=0, playing=0, game_over=1.
  - A hit in the same cycle as time_left reaching 0 is still scored.
  - score and misses are frozen in OVER.
- OVER: on start -> GAP with the same clears as from IDLE.
- start in GAP/UP is ignored.
- Latency: outputs are registered. score, misses and led update on the edge that samples the whack, i.e. one cycle after sw changes relative to sw_q.

Test Plan:
- CLK_IN_FREQ_HZ=10_000, GAME_SECONDS=3, GAP_MS=2. Reset, then start pulse -> playing=1 next cycle; after 20 cycles led one-hot with a value derived from LFSR_SEED; time_left=2 after 10_000 cycles.
- Toggle sw[hole] while mole is up -> next edge score=1, led=0, up_ms=950; next mole lands on a different hole than the previous one.
- Toggle a wrong sw bit in UP -> misses=1, led unchanged. Toggle three wrong bits in one cycle -> misses+1 only. Toggle correct plus wrong bits together -> score+1, misses unchanged.
- Never whack -> after MOLE_UP_MS_INIT ms_ticks led clears and misses=1. After 14 hits, up_ms holds at 300.
- Run the full round -> game_over=1 when time_left=0; whacks in OVER ignored; start restarts with score=0 and time_left=3. Score saturates at 255 with SCORE_BITS=8 (forced long round).
- Assert reset mid-UP -> next edge IDLE, led=0, all counts at reset values; start during UP has no effect.
